// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU:
// opcode encodings and FSM state type.
package alu_pkg;

  localparam logic [5:0] OP_ADD  = 6'd27;
  localparam logic [5:0] OP_SUB  = 6'd28;
  localparam logic [5:0] OP_SRL  = 6'd29;
  localparam logic [5:0] OP_SLL  = 6'd30;
  localparam logic [5:0] OP_XOR  = 6'd31;
  localparam logic [5:0] OP_AND  = 6'd32;
  localparam logic [5:0] OP_OR   = 6'd33;
  localparam logic [5:0] OP_SRA  = 6'd34;
  localparam logic [5:0] OP_MULU = 6'd35;
  localparam logic [5:0] OP_DIVU = 6'd36;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result handshake bundle between the
// execute-stage controller and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       operation;
  logic [WIDTH-1:0] Source1;
  logic [WIDTH-1:0] Source2;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             carry;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, operation, Source1,
    output Source2, shamt, out_ready,
    input  in_ready, out_valid, result,
    input  hi, carry, zero, illegal
  );

  modport slave (
    input  in_valid, operation, Source1,
    input  Source2, shamt, out_ready,
    output in_ready, out_valid, result,
    output hi, carry, zero, illegal
  );
endinterface

// File: rtl/alu_iter_core.sv
// WIDTH-step shift-add multiplier / restoring divider.
// o_lo/o_hi present the value of the step taken this cycle.
module alu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);
  localparam int CW = $clog2(WIDTH);

  logic             r_run;
  logic             r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_mlo;
  logic [WIDTH-1:0] w_mhi;
  logic [WIDTH-1:0] w_dlo;
  logic [WIDTH-1:0] w_dhi;

  always_comb begin
    w_sum = {1'b0, r_hi};
    if (r_lo[0])
      w_sum = {1'b0, r_hi} + {1'b0, r_b};
    w_mhi = w_sum[WIDTH:1];
    w_mlo = {w_sum[0], r_lo[WIDTH-1:1]};
  end

  // With r_b == 0 every step subtracts nothing, so the
  // quotient fills with ones and the remainder becomes A.
  always_comb begin
    w_t   = {r_hi, r_lo[WIDTH-1]};
    w_ge  = (w_t >= {1'b0, r_b});
    w_dhi = w_t[WIDTH-1:0];
    if (w_ge)
      w_dhi = w_t[WIDTH-1:0] - r_b;
    w_dlo = {r_lo[WIDTH-2:0], w_ge};
  end

  assign o_lo   = r_div ? w_dlo : w_mlo;
  assign o_hi   = r_div ? w_dhi : w_mhi;
  assign o_busy = r_run && (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_b   <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_div <= i_is_div;
      r_cnt <= CW'(WIDTH - 1);
      r_lo  <= i_a;
      r_hi  <= '0;
      r_b   <= i_b;
    end else if (r_run) begin
      r_lo <= o_lo;
      r_hi <= o_hi;
      if (r_cnt == '0)
        r_run <= 1'b0;
      else
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: handshake FSM and
// single-cycle datapath; mul/div delegated to alu_iter_core.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  io_bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic             r_carry;
  logic             r_illegal;

  logic             w_iter;
  logic             w_start;
  logic             w_load_sc;
  logic             w_load_it;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_ill;
  logic             w_busy;
  logic [WIDTH-1:0] w_lo_it;
  logic [WIDTH-1:0] w_hi_it;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [SHW-1:0]   w_sh;
  logic [5:0]       w_op;

  assign w_a    = io_bus.Source1;
  assign w_b    = io_bus.Source2;
  assign w_sh   = io_bus.shamt;
  assign w_op   = io_bus.operation;
  assign w_iter = (w_op == OP_MULU) || (w_op == OP_DIVU);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_ill = 1'b0;
    unique case (1'b1)
      (w_op == OP_ADD):  {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b};
      (w_op == OP_SUB):  {w_c, w_res} = {1'b0, w_a} - {1'b0, w_b};
      (w_op == OP_SRL):  w_res = w_a >> w_sh;
      (w_op == OP_SLL):  w_res = w_a << w_sh;
      (w_op == OP_XOR):  w_res = w_a ^ w_b;
      (w_op == OP_AND):  w_res = w_a & w_b;
      (w_op == OP_OR):   w_res = w_a | w_b;
      (w_op == OP_SRA):  w_res = $signed(w_a) >>> w_sh;
      (w_op == OP_MULU): w_ill = 1'b0;
      (w_op == OP_DIVU): w_ill = 1'b0;
      default:           w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_load_sc = 1'b0;
    w_load_it = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (io_bus.in_valid) begin
          if (w_iter) begin
            w_next  = RUN;
            w_start = 1'b1;
          end else begin
            w_next    = DONE;
            w_load_sc = 1'b1;
          end
        end
      end
      RUN: begin
        if (!w_busy) begin
          w_next    = DONE;
          w_load_it = 1'b1;
        end
      end
      DONE: begin
        if (io_bus.out_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_hi      <= '0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load_sc) begin
      r_result  <= w_res;
      r_hi      <= '0;
      r_carry   <= w_c;
      r_illegal <= w_ill;
    end else if (w_load_it) begin
      r_result  <= w_lo_it;
      r_hi      <= w_hi_it;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  alu_iter_core #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .i_is_div (w_op == OP_DIVU),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_busy   (w_busy),
    .o_lo     (w_lo_it),
    .o_hi     (w_hi_it)
  );

  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_valid = (r_state == DONE);
  assign io_bus.result    = r_result;
  assign io_bus.hi        = r_hi;
  assign io_bus.carry     = r_carry;
  assign io_bus.illegal   = r_illegal;
  assign io_bus.zero      = (r_result == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32.
// Inputs driven and outputs sampled on the falling edge.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_mc_if #(.WIDTH(32)) bus ();

  alu_mc #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_op(input logic [5:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] sh,
                        output int lat,
                        output bit rdy_seen);
    lat = -1;
    rdy_seen = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operation = op;
    bus.Source1   = a;
    bus.Source2   = b;
    bus.shamt     = sh;
    @(posedge clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.in_ready) rdy_seen = 1'b1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic ack();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.operation = '0;
    bus.Source1 = '0;
    bus.Source2 = '0;
    bus.shamt = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.carry,
         bus.zero, bus.illegal} !== 5'b10010) begin
      errors++;
      $display("FAIL reset_flags got %b exp 10010",
        {bus.in_ready, bus.out_valid, bus.carry,
         bus.zero, bus.illegal});
    end
    checks++;
    if ({bus.result, bus.hi} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0",
        {bus.result, bus.hi});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    bit rs;
    run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0, lat, rs);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL add_latency got %0d exp 1", lat);
    end
    checks++;
    if ({bus.result, bus.carry, bus.zero, bus.hi} !==
        {32'h0, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL add_wrap got r=%h c=%b z=%b exp r=0 c=1 z=1",
        bus.result, bus.carry, bus.zero);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_in_ready got %b exp 0", bus.in_ready);
    end
    ack();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_in_ready got %b exp 1", bus.in_ready);
    end
    run_op(OP_ADD, 32'h2, 32'h3, 5'd0, lat, rs);
    checks++;
    if ({bus.result, bus.carry, bus.zero} !==
        {32'h5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_small got r=%h c=%b z=%b exp r=5 c=0 z=0",
        bus.result, bus.carry, bus.zero);
    end
    ack();
  endtask

  task automatic test_sub_sra();
    int lat;
    bit rs;
    run_op(OP_SUB, 32'h3, 32'h5, 5'd0, lat, rs);
    checks++;
    if ({bus.result, bus.carry} !== {32'hFFFF_FFFE, 1'b1}) begin
      errors++;
      $display("FAIL sub_borrow got r=%h c=%b exp r=fffffffe c=1",
        bus.result, bus.carry);
    end
    ack();
    run_op(OP_SUB, 32'h9, 32'h4, 5'd0, lat, rs);
    checks++;
    if ({bus.result, bus.carry} !== {32'h5, 1'b0}) begin
      errors++;
      $display("FAIL sub_noborrow got r=%h c=%b exp r=5 c=0",
        bus.result, bus.carry);
    end
    ack();
    run_op(OP_SRA, 32'h8000_0000, 32'h0, 5'd4, lat, rs);
    checks++;
    if (bus.result !== 32'hF800_0000) begin
      errors++;
      $display("FAIL sra got %h exp f8000000", bus.result);
    end
    ack();
  endtask

  task automatic test_logic();
    logic [5:0]  ops [5] = '{OP_XOR, OP_AND, OP_OR, OP_SRL, OP_SLL};
    logic [31:0] as  [5] = '{32'hA5A5_A5A5, 32'hF0F0_F0F0,
                            32'h1234_0000, 32'h8000_0000, 32'h1};
    logic [31:0] bs  [5] = '{32'h0F0F_0F0F, 32'h3C3C_3C3C,
                            32'h0000_5678, 32'h0, 32'h0};
    logic [4:0]  shs [5] = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
    logic [31:0] exs [5] = '{32'hAAAA_AAAA, 32'h3030_3030,
                            32'h1234_5678, 32'h1, 32'h8000_0000};
    int lat;
    bit rs;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], shs[i], lat, rs);
      checks++;
      if ({bus.result, bus.hi, bus.carry, bus.illegal} !==
          {exs[i], 32'h0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL logic_op%0d got r=%h hi=%h c=%b il=%b exp r=%h",
          ops[i], bus.result, bus.hi, bus.carry, bus.illegal, exs[i]);
      end
      ack();
    end
  endtask

  task automatic test_mulu();
    int lat;
    bit rs;
    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat, rs);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL mulu_latency got %0d exp 33", lat);
    end
    checks++;
    if (rs !== 1'b0) begin
      errors++;
      $display("FAIL mulu_in_ready got %b exp 0", rs);
    end
    checks++;
    if ({bus.hi, bus.result} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL mulu_max got %h exp fffffffe00000001",
        {bus.hi, bus.result});
    end
    ack();
    run_op(OP_MULU, 32'h0001_0000, 32'h0001_0000, 5'd0, lat, rs);
    checks++;
    if ({bus.hi, bus.result, bus.zero} !==
        {64'h0000_0001_0000_0000, 1'b1}) begin
      errors++;
      $display("FAIL mulu_pow2 got %h z=%b exp 100000000 z=1",
        {bus.hi, bus.result}, bus.zero);
    end
    ack();
  endtask

  task automatic test_divu();
    int lat;
    bit rs;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, lat, rs);
    checks++;
    if ({bus.result, bus.hi, lat} !== {32'd14, 32'd2, 32'd33}) begin
      errors++;
      $display("FAIL divu_100_7 got q=%0d r=%0d lat=%0d exp 14 2 33",
        bus.result, bus.hi, lat);
    end
    ack();
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd0, lat, rs);
    checks++;
    if ({bus.result, bus.hi, bus.illegal} !==
        {32'hFFFF_FFFF, 32'd5, 1'b0}) begin
      errors++;
      $display("FAIL divu_by0 got q=%h r=%h il=%b exp ffffffff 5 0",
        bus.result, bus.hi, bus.illegal);
    end
    ack();
  endtask

  task automatic test_hold_illegal();
    int lat;
    bit rs;
    run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, lat, rs);
    bus.in_valid  = 1'b1;
    bus.operation = OP_ADD;
    bus.Source1   = 32'h1;
    bus.Source2   = 32'h1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.hi} !==
          {1'b1, 1'b0, 32'd14, 32'd2}) begin
        errors++;
        $display("FAIL hold_c%0d got v=%b rdy=%b r=%h hi=%h exp 1 0 e 2",
          i, bus.out_valid, bus.in_ready, bus.result, bus.hi);
      end
    end
    bus.in_valid = 1'b0;
    ack();
    run_op(OP_SUB, 32'h0, 32'h1, 5'd0, lat, rs);
    ack();
    run_op(6'd40, 32'h1234, 32'h5678, 5'd3, lat, rs);
    checks++;
    if ({bus.result, bus.hi, bus.carry, bus.illegal, bus.zero, lat} !==
        {32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL illegal_op got r=%h hi=%h c=%b il=%b lat=%0d",
        bus.result, bus.hi, bus.carry, bus.illegal, lat);
    end
    ack();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bit rs;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.operation = OP_MULU;
    bus.Source1   = 32'hFFFF_FFFF;
    bus.Source2   = 32'h3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.carry, bus.zero,
         bus.illegal, bus.result, bus.hi} !==
        {5'b10010, 64'h0}) begin
      errors++;
      $display("FAIL midrun_reset got rdy=%b v=%b il=%b r=%h hi=%h",
        bus.in_ready, bus.out_valid, bus.illegal, bus.result, bus.hi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_ADD, 32'h2, 32'h2, 5'd0, lat, rs);
    checks++;
    if ({bus.result, lat} !== {32'h4, 32'd1}) begin
      errors++;
      $display("FAIL post_reset_add got r=%h lat=%0d exp 4 1",
        bus.result, lat);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_sra();
    test_logic();
    test_mulu();
    test_divu();
    test_hold_illegal();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
